// File: rtl/lc4_seq_muldiv.sv
// ---------------------------------------------------------------------------
// lc4_seq_muldiv
//
// Multi-cycle unsigned multiply/divide unit that sits beside the LC4 ALU in
// the execute stage. It accepts one operation over a valid/ready handshake,
// iterates one bit per cycle, and holds the result until the consumer takes
// it. The pipeline stalls on o_ready/o_valid.
//
// Ports:
//   clk       clock
//   rst_n     synchronous active-low reset (acts regardless of gwe)
//   gwe       global write enable; when low nothing updates
//   i_valid   request valid
//   o_ready   unit can accept a request (state == IDLE)
//   i_op      00 MUL (low half), 01 DIV, 10 MOD, 11 MULHU (high half)
//   i_a       multiplicand / dividend
//   i_b       multiplier / divisor
//   i_flush   abort any in-flight or completed operation
//   o_valid   result valid (state == DONE)
//   i_ready   consumer takes the result
//   o_result  registered result
//
// Optional feature macro: LC4_MULDIV_EARLY_OUT_EN
//   When defined, MUL/MULHU finish as soon as the multiplier register
//   becomes zero (and immediately when i_b == 0).
// ---------------------------------------------------------------------------
module lc4_seq_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gwe,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_DIV   = 2'b01;
  localparam logic [1:0] OP_MOD   = 2'b10;
  localparam logic [1:0] OP_MULHU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  // opa: multiplicand (shifted left each MUL step) or divisor (low half).
  logic [2*WIDTH-1:0]   opa_q, opa_d;
  // opb: multiplier (shifted right) or dividend/quotient shift register.
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic                 i_is_div;
  logic                 q_is_div;
  logic                 last_iter;
  logic                 done_now;
  logic [2*WIDTH-1:0]   mul_prod;
  logic [WIDTH:0]       rem_shift;
  logic                 div_ge;

  // Datapath helpers for a single iteration of either algorithm.
  assign i_is_div  = (i_op == OP_DIV) || (i_op == OP_MOD);
  assign q_is_div  = (op_q == OP_DIV) || (op_q == OP_MOD);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign mul_prod  = opb_q[0] ? (prod_q + opa_q) : prod_q;
  // Restoring division: the shifted partial remainder needs one extra bit
  // before the trial subtraction.
  assign rem_shift = {rem_q, opb_q[WIDTH-1]};
  assign div_ge    = (rem_shift >= {1'b0, opa_q[WIDTH-1:0]});

  // Next-state and datapath: registers hold unless a step below updates them.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    result_d = result_q;
    done_now = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_valid && !i_flush) begin
          op_d   = i_op;
          cnt_d  = '0;
          prod_d = '0;
          rem_d  = '0;
          if (i_is_div) begin
            opa_d = {{WIDTH{1'b0}}, i_b};
            opb_d = i_a;
          end else begin
            opa_d = {{WIDTH{1'b0}}, i_a};
            opb_d = i_b;
          end
          // Divide-by-zero returns 0 without iterating.
          if (i_is_div && (i_b == '0)) begin
            result_d = '0;
            state_d  = S_DONE;
          end
`ifdef LC4_MULDIV_EARLY_OUT_EN
          else if (!i_is_div && (i_b == '0)) begin
            result_d = '0;
            state_d  = S_DONE;
          end
`endif
          else begin
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (q_is_div) begin
          // Fold the subtraction into WIDTH bits: when div_ge holds the
          // true difference is below the divisor, so it always fits.
          rem_d = div_ge ? (rem_shift[WIDTH-1:0] - opa_q[WIDTH-1:0])
                         : rem_shift[WIDTH-1:0];
          opb_d = {opb_q[WIDTH-2:0], div_ge};
        end else begin
          prod_d = mul_prod;
          opa_d  = opa_q << 1;
          opb_d  = opb_q >> 1;
        end

        done_now = last_iter;
`ifdef LC4_MULDIV_EARLY_OUT_EN
        if (!q_is_div && (opb_d == '0)) begin
          done_now = 1'b1;
        end
`endif

        if (done_now) begin
          state_d = S_DONE;
          case (op_q)
            OP_MUL:   result_d = mul_prod[WIDTH-1:0];
            OP_MULHU: result_d = mul_prod[2*WIDTH-1:WIDTH];
            OP_DIV:   result_d = opb_d;
            default:  result_d = rem_d;
          endcase
        end
      end

      S_DONE: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Flush outranks any handshake; reset outranks flush in the register.
    if (i_flush) begin
      state_d = S_IDLE;
    end
  end

  // State and datapath registers; gwe freezes everything except reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else if (gwe) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign o_result = result_q;

endmodule

// File: tb/tb_lc4_seq_muldiv.sv
// ---------------------------------------------------------------------------
// tb_lc4_seq_muldiv
//
// Directed self-checking bench for lc4_seq_muldiv (WIDTH = 16). Cycle 0 is
// the cycle a request is presented; cycle k is observed 1 time unit after
// the k-th following rising edge.
// ---------------------------------------------------------------------------
module tb_lc4_seq_muldiv;

  localparam int WIDTH = 16;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_DIV   = 2'b01;
  localparam logic [1:0] OP_MOD   = 2'b10;
  localparam logic [1:0] OP_MULHU = 2'b11;

`ifdef LC4_MULDIV_EARLY_OUT_EN
  localparam int LAT_MUL_3_5  = 4;
  localparam int LAT_MUL_B0   = 1;
  localparam int LAT_MUL_7_9  = 5;
`else
  localparam int LAT_MUL_3_5  = 17;
  localparam int LAT_MUL_B0   = 17;
  localparam int LAT_MUL_7_9  = 17;
`endif

  logic             clk;
  logic             rst_n;
  logic             gwe;
  logic             i_valid;
  logic             o_ready;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_flush;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;

  int n_cmp;
  int n_err;

  lc4_seq_muldiv #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .gwe      (gwe),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request in cycle 0; returns observing cycle 1.
  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a,
                               input logic [15:0] b);
    i_valid = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    step();
    i_valid = 1'b0;
  endtask

  // Bounded wait for o_valid; lat stays 0 if it never rises.
  task automatic waitValid(input int start, output int lat);
    lat = 0;
    for (int c = start; c <= start + 40; c++) begin
      if (o_valid) begin
        lat = c;
        break;
      end
      step();
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_res, input int exp_lat);
    int lat;
    applyStimulus(op, a, b);
    waitValid(1, lat);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_res"}, 32'(o_result), 32'(exp_res));
    step();
  endtask

  initial begin
    int lat;
    int seen;
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    gwe     = 1'b0;
    i_valid = 1'b0;
    i_op    = 2'b00;
    i_a     = '0;
    i_b     = '0;
    i_flush = 1'b0;
    i_ready = 1'b1;

    // Reset acts even with gwe low.
    step();
    step();
    checkOutput("rst_ready",  32'(o_ready),  32'd1);
    checkOutput("rst_valid",  32'(o_valid),  32'd0);
    checkOutput("rst_result", 32'(o_result), 32'd0);
    rst_n = 1'b1;
    gwe   = 1'b1;
    step();

    // Basic arithmetic.
    runOp("mul_3_5",     OP_MUL,   16'h0003, 16'h0005, 16'h000F, LAT_MUL_3_5);
    runOp("div_100_7",   OP_DIV,   16'd100,  16'd7,    16'h000E, 17);
    runOp("mod_100_7",   OP_MOD,   16'd100,  16'd7,    16'h0002, 17);
    runOp("div_ffff_1",  OP_DIV,   16'hFFFF, 16'h0001, 16'hFFFF, 17);
    runOp("mod_5_9",     OP_MOD,   16'd5,    16'd9,    16'h0005, 17);
    runOp("mulhu_ffff",  OP_MULHU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17);
    runOp("div_by_zero", OP_DIV,   16'h1234, 16'h0000, 16'h0000, 1);
    runOp("mul_ffff",    OP_MUL,   16'hFFFF, 16'hFFFF, 16'h0001, 17);
    runOp("mod_by_zero", OP_MOD,   16'h1234, 16'h0000, 16'h0000, 1);
    runOp("mul_by_zero", OP_MUL,   16'h1234, 16'h0000, 16'h0000, LAT_MUL_B0);

    // gwe low for 3 cycles mid-BUSY stretches latency by 3.
    applyStimulus(OP_DIV, 16'd100, 16'd7);
    repeat (4) step();
    gwe = 1'b0;
    repeat (3) step();
    gwe = 1'b1;
    waitValid(8, lat);
    checkOutput("stall_lat", 32'(lat), 32'd20);
    checkOutput("stall_res", 32'(o_result), 32'h000E);
    step();

    // Backpressure: result held while i_ready is low.
    i_ready = 1'b0;
    applyStimulus(OP_MOD, 16'd100, 16'd7);
    waitValid(1, lat);
    checkOutput("bp_lat", 32'(lat), 32'd17);
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput("bp_hold", {15'd0, o_valid, o_result}, {15'd0, 1'b1, 16'h0002});
    end
    // gwe low blocks consumption.
    gwe     = 1'b0;
    i_ready = 1'b1;
    step();
    checkOutput("gwe_blocks_consume", 32'(o_valid), 32'd1);
    gwe = 1'b1;
    // Request raised in the consume cycle is accepted one cycle later.
    i_valid = 1'b1;
    i_op    = OP_MUL;
    i_a     = 16'h0003;
    i_b     = 16'h0005;
    step();
    checkOutput("b2b_ready_after_consume", {o_ready, o_valid}, 32'b10);
    step();
    i_valid = 1'b0;
    waitValid(1, lat);
    checkOutput("b2b_lat", 32'(lat), 32'(LAT_MUL_3_5));
    checkOutput("b2b_res", 32'(o_result), 32'h000F);
    step();

    // Flush in cycle 8 of a DIV.
    applyStimulus(OP_DIV, 16'd100, 16'd7);
    repeat (7) step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    checkOutput("flush_ready", {o_ready, o_valid}, 32'b10);
    seen = 0;
    repeat (20) begin
      step();
      if (o_valid) seen = 1;
    end
    checkOutput("flush_no_valid", 32'(seen), 32'd0);

    // Flush in IDLE rejects a simultaneous request.
    i_valid = 1'b1;
    i_flush = 1'b1;
    i_op    = OP_MUL;
    i_a     = 16'h0002;
    i_b     = 16'h0002;
    step();
    i_valid = 1'b0;
    i_flush = 1'b0;
    checkOutput("flush_idle_reject", 32'(o_ready), 32'd1);
    step();
    checkOutput("flush_idle_still_idle", {o_ready, o_valid}, 32'b10);

    // Reset mid-BUSY returns all outputs to reset values.
    applyStimulus(OP_MUL, 16'd7, 16'd9);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checkOutput("midrst_ready",  32'(o_ready),  32'd1);
    checkOutput("midrst_valid",  32'(o_valid),  32'd0);
    checkOutput("midrst_result", 32'(o_result), 32'd0);
    runOp("mul_after_reset", OP_MUL, 16'd7, 16'd9, 16'h003F, LAT_MUL_7_9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lc4_seq_muldiv.md
# lc4_seq_muldiv

Parametrised multi-cycle unsigned multiply/divide unit for the LC4 pipeline, taking MUL/DIV/MOD off the single-cycle ALU's critical path. Accepts one operation through a valid/ready handshake, iterates one bit per cycle, and holds the result until the consumer takes it. It sits beside the ALU in the execute stage. The pipeline stalls on `o_ready`/`o_valid`.

## Interface
- `WIDTH`, 16: operand/result width. Must be ≥4.
- `clk`  in  1  clock. Reset is synchronous and active-low.
- `rst_n`  in  1  synchronous active-low reset.
- `gwe`  in  1  global write enable. When low, no register in the block updates and no handshake completes.
- `i_valid`  in  1  request valid.
- `o_ready`  out  1  unit can accept a request. Equals state==IDLE.
- `i_op`  in  2  operation: 00 MUL (low WIDTH bits of product), 01 DIV (quotient), 10 MOD (remainder), 11 MULHU (high WIDTH bits of unsigned product).
- `i_a`  in  WIDTH  multiplicand / dividend.
- `i_b`  in  WIDTH  multiplier / divisor.
- `i_flush`  in  1  abort any in-flight or completed operation.
- `o_valid`  out  1  result valid. Equals state==DONE.
- `i_ready`  in  1  consumer takes result.
- `o_result`  out  WIDTH  result. Registered.

## Operation
- States: IDLE, BUSY, DONE. All updates below require `gwe`=1 unless noted.
- Reset (`rst_n`=0 at edge, regardless of `gwe`):
  - state→IDLE.
  - `o_result`→0, `o_valid`=0, `o_ready`=1.
  - Iteration counter, operand, product and remainder registers→0.
- IDLE:
  - Acceptance is `i_valid && o_ready && !i_flush`. On acceptance, latch `i_op`, `i_a`, `i_b` and clear the counter.
  - DIV/MOD with `i_b`==0: go directly to DONE with `o_result`=0 (LC4 divide-by-zero convention).
  - Otherwise go to BUSY.
- BUSY performs one iteration per cycle:
  - MUL/MULHU: shift-add. If the LSB of the multiplier register is set, add the multiplicand into the 2·WIDTH product. Then shift the multiplicand left and the multiplier right. The result is the low or high half of the product.
  - DIV/MOD: restoring division. Shift {rem, quotient} left by 1. Trial-subtract the divisor using a WIDTH+1-bit remainder. Keep the difference if it is non-negative, and set the quotient LSB accordingly.
  - After iteration WIDTH-1, load `o_result` and go to DONE.
- DONE: `o_result` is held stable. `i_ready`=1 → IDLE.
- `i_flush`=1 (with `gwe`): state→IDLE from any state and the result is discarded. Priority is reset > flush > handshake.
- Arithmetic is unsigned, modulo 2^WIDTH. There are no sign or overflow outputs.

## Timing
- Acceptance happens in cycle 0.
- BUSY occupies cycles 1..WIDTH. DONE (`o_valid`=1) first appears in cycle WIDTH+1 (cycle 17 for WIDTH=16).
- Divide-by-zero (and MUL early-out with `i_b`=0) gives `o_valid` in cycle 1.
- Result consumed in cycle n: `o_ready`=1 in cycle n+1. A back-to-back request is accepted in cycle n+1, not n. At most one operation is in flight.
- `gwe`=0 for k cycles in BUSY stretches latency by exactly k. `gwe`=0 in DONE blocks consumption.
- Backpressure: `o_result` and `o_valid` stay constant while `i_ready`=0.
- Flush in IDLE with `i_valid`=1: the request is not accepted.

## Configuration
- `LC4_MULDIV_EARLY_OUT_EN` defined:
  - MUL/MULHU go to DONE at the end of the first BUSY iteration that leaves the multiplier register zero.
  - With `i_b`==0 they go directly to DONE from IDLE.
  - Results are identical and latency varies. For example, `i_b`=5 gives `o_valid` in cycle 4.
- Not defined: every non-divide-by-zero operation takes exactly WIDTH BUSY cycles.

## Test plan
- MUL `i_a`=0x0003, `i_b`=0x0005, `i_ready`=1 → `o_result`=0x000F with `o_valid` in cycle 17. With `LC4_MULDIV_EARLY_OUT_EN` defined, `o_valid` is in cycle 4.
- DIV 100/7 → 0x000E. MOD 100/7 → 0x0002. DIV 0xFFFF/0x0001 → 0xFFFF. MOD 5/9 → 0x0005.
- DIV and MOD 0x1234/0 → `o_result`=0x0000 and `o_valid` in cycle 1. MUL 0x1234·0 → 0x0000 in cycle 17 (no early-out).
- MULHU 0xFFFF·0xFFFF → 0xFFFE. MUL of the same operands → 0x0001.
- Stall and backpressure:
  - `gwe`=0 for 3 cycles mid-BUSY → `o_valid` appears in cycle 20.
  - `i_ready`=0 for 5 cycles in DONE → `o_result` is stable.
  - `i_valid` high in the consume cycle → the request is accepted the next cycle.
- Abort:
  - `i_flush` in cycle 8 of a DIV → `o_valid` is never asserted and `o_ready`=1 in cycle 9.
  - `rst_n`=0 mid-BUSY → all outputs are at their reset values the next cycle.
  - A new MUL then completes correctly.
